// File: rtl/fb_scanout.sv
// fb_scanout: reads a frame buffer out of word memory into a pixel FIFO, sharing the memory port with host writes
module fb_scanout #(
    parameter int FRAME_WORDS = 4800,
    parameter int BASE_ADDR   = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [15:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_addr,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_mask,
    output logic        px_valid,
    input  logic        px_ready,
    output logic [15:0] px_data,
    output logic        px_sof
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] FIRST = 16'(BASE_ADDR);
    localparam logic [15:0] LAST = 16'(BASE_ADDR + FRAME_WORDS - 1);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] TWO = (AW+1)'(2);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state_q, state_d;
    logic [15:0]   ptr_q, ptr_d;
    logic          fly_q, fly_d;
    logic          fly_sof_q, fly_sof_d;
    logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [15:0]   fifo_data_q [FIFO_DEPTH];
    logic          fifo_sof_q [FIFO_DEPTH];
    logic [AW:0]   credits;
    logic          wr_go, rd_go, flush, pop;

    // Memory port arbitration: a write needs two spare credits while running so reads keep flowing
    always_comb begin
        credits   = cnt_q + (AW+1)'(fly_q);
        wr_go     = wr_valid && (state_q == IDLE || credits >= TWO);
        rd_go     = !wr_go && state_q == RUN && credits < DEPTH;
        wr_ready  = wr_go;
        mem_addr  = wr_go ? wr_addr : (rd_go ? ptr_q : '0);
        mem_we    = wr_go ? wr_mask : '0;
        mem_wdata = wr_go ? wr_data : '0;
        px_valid  = cnt_q != '0;
        px_data   = px_valid ? fifo_data_q[rp_q] : '0;
        px_sof    = px_valid && fifo_sof_q[rp_q];
        pop       = px_valid && px_ready;
    end

    // Next state: leaving RUN flushes the FIFO, drops the pending read and rewinds the pointer
    always_comb begin
        state_d   = enable ? RUN : IDLE;
        flush     = state_q == RUN && !enable;
        ptr_d     = flush ? FIRST : (rd_go ? (ptr_q == LAST ? FIRST : ptr_q + 16'd1) : ptr_q);
        fly_d     = rd_go && !flush;
        fly_sof_d = ptr_q == FIRST;
        rp_d      = flush ? '0 : rp_q + AW'(pop);
        wp_d      = flush ? '0 : wp_q + AW'(fly_q);
        cnt_d     = flush ? '0 : cnt_q + (AW+1)'(fly_q) - (AW+1)'(pop);
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= FIRST;
            fly_q     <= 1'b0;
            fly_sof_q <= 1'b0;
            rp_q      <= '0;
            wp_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            fly_q     <= fly_d;
            fly_sof_q <= fly_sof_d;
            rp_q      <= rp_d;
            wp_q      <= wp_d;
            cnt_q     <= cnt_d;
        end
    end

    // FIFO storage: read data lands one cycle after its address; contents are gated by px_valid
    always_ff @(posedge clk) begin
        if (fly_q && !flush) begin
            fifo_data_q[wp_q] <= mem_rdata;
            fifo_sof_q[wp_q]  <= fly_sof_q;
        end
    end
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: table-driven and scoreboard checks of frame scanout, host writes, flush and reset
module tb_fb_scanout;
    localparam int FW = 8;
    localparam int BA = 0;
    localparam int FD = 4;

    logic        clk = 1'b0;
    logic        rst, enable, wr_valid, wr_ready, px_valid, px_ready, px_sof;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, wr_addr, wr_data, px_data;
    logic [3:0]  mem_we, wr_mask;

    typedef struct packed {logic [15:0] data; logic sof;} px_t;
    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [15:0] data;
        logic [3:0]  mask;
        logic        exp_ready;
        logic [3:0]  exp_we;
        logic [15:0] exp_word;
    } vec_t;

    px_t         sb[$];
    logic [15:0] mem_m [256];
    logic [15:0] ref_m [256];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc, first;
    vec_t        vecs [4];

    fb_scanout #(.FRAME_WORDS(FW), .BASE_ADDR(BA), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_sof(px_sof)
    );

    always #5 clk = ~clk;

    // Word memory with nibble write mask and one-cycle read latency
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_we[b]) mem_m[mem_addr[7:0]][4*b +: 4] <= mem_wdata[4*b +: 4];
        mem_rdata <= mem_m[mem_addr[7:0]];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Pixel monitor: every accepted word is compared against the scoreboard head
    always @(negedge clk) begin
        if (!rst && px_valid && px_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                px_t e;
                e = sb.pop_front();
                chk("px_data", px_data, e.data);
                chk("px_sof", px_sof, e.sof);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        sb.delete();
        for (int k = 0; k < n; k++) sb.push_back('{data: ref_m[BA + k % FW], sof: (k % FW) == 0});
        enable = 1'b1;
    endtask

    task automatic drain(input bit rnd, output int c, output int f);
        c = 0;
        f = -1;
        px_ready = 1'b1;
        while (sb.size() != 0 && c < 400) begin
            tick();
            c++;
            if (px_valid && f < 0) f = c;
            if (rnd) px_ready = 1'($urandom_range(0, 1));
        end
        chk("drain_left", sb.size(), 0);
        if (!rnd) chk("valid_before_stop", px_valid, 1);
        enable = 1'b0;
        px_ready = 1'b0;
        tick();
        chk("flush_valid", px_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_m[i] = 16'(i);
            ref_m[i] = 16'(i);
        end
        vecs[0] = '{1'b0, 16'd5, 16'h1111, 4'hF, 1'b0, 4'h0, 16'h0005};
        vecs[1] = '{1'b1, 16'd3, 16'hABCD, 4'hF, 1'b1, 4'hF, 16'hABCD};
        vecs[2] = '{1'b1, 16'd6, 16'hFFFF, 4'h0, 1'b1, 4'h0, 16'h0006};
        vecs[3] = '{1'b1, 16'd5, 16'h1234, 4'h5, 1'b1, 4'h5, 16'h0204};
        rst = 1'b1; enable = 1'b0; px_ready = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_px_valid", px_valid, 0);
        chk("rst_px_sof", px_sof, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_px_data", px_data, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0;
        tick();
        // Host writes while idle
        for (int i = 0; i < 4; i++) begin
            wr_valid = vecs[i].valid; wr_addr = vecs[i].addr;
            wr_data = vecs[i].data; wr_mask = vecs[i].mask;
            #1;
            chk("vec_wr_ready", wr_ready, vecs[i].exp_ready);
            chk("vec_mem_we", mem_we, vecs[i].exp_we);
            if (vecs[i].exp_ready) begin
                chk("vec_mem_addr", mem_addr, vecs[i].addr);
                chk("vec_mem_wdata", mem_wdata, vecs[i].data);
            end
            tick();
            chk("vec_mem_word", mem_m[vecs[i].addr[7:0]], vecs[i].exp_word);
            ref_m[vecs[i].addr[7:0]] = vecs[i].exp_word;
        end
        wr_valid = 1'b0;
        tick();
        // Continuous scanout: latency and one word per cycle
        start(20);
        drain(1'b0, cyc, first);
        chk("first_valid_latency", first, 3);
        chk("throughput_cycles", cyc, 23);
        // Stop mid-frame after word 5, restart two cycles later
        start(5);
        drain(1'b0, cyc, first);
        repeat (2) tick();
        start(10);
        drain(1'b0, cyc, first);
        chk("restart_latency", first, 3);
        // Backpressure: hold px_ready low for 20 cycles
        start(12);
        repeat (20) tick();
        chk("stall_valid", px_valid, 1);
        chk("stall_data", px_data, ref_m[BA]);
        chk("stall_sof", px_sof, 1);
        chk("stall_we", mem_we, 0);
        tick();
        chk("stall_data_stable", px_data, ref_m[BA]);
        drain(1'b0, cyc, first);
        // Writes accepted back to back while the FIFO is full
        start(10);
        repeat (10) tick();
        for (int k = 0; k < 3; k++) begin
            wr_valid = 1'b1; wr_addr = 16'(100 + k); wr_data = 16'hC0DE + 16'(k); wr_mask = 4'hF;
            #1;
            chk("full_wr_ready", wr_ready, 1);
            chk("full_mem_we", mem_we, 4'hF);
            chk("full_mem_addr", mem_addr, 100 + k);
            tick();
        end
        wr_valid = 1'b0;
        tick();
        for (int k = 0; k < 3; k++) chk("full_mem_word", mem_m[100 + k], 16'hC0DE + 16'(k));
        chk("full_px_data", px_data, ref_m[BA]);
        drain(1'b0, cyc, first);
        // Write refused at run start when credits are low
        start(6);
        tick();
        wr_valid = 1'b1; wr_addr = 16'd200; wr_data = 16'h5555; wr_mask = 4'hF;
        #1;
        chk("low_credit_wr_ready", wr_ready, 0);
        chk("low_credit_mem_we", mem_we, 0);
        chk("low_credit_read_addr", mem_addr, BA);
        wr_valid = 1'b0;
        drain(1'b0, cyc, first);
        chk("low_credit_no_write", mem_m[200], 200);
        // Random backpressure
        start(16);
        drain(1'b1, cyc, first);
        // Asynchronous reset in mid-frame
        start(30);
        px_ready = 1'b1;
        repeat (6) tick();
        chk("pre_rst_valid", px_valid, 1);
        rst = 1'b1;
        enable = 1'b0;
        #1;
        chk("async_rst_valid", px_valid, 0);
        chk("async_rst_we", mem_we, 0);
        chk("async_rst_sof", px_sof, 0);
        px_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
        start(10);
        drain(1'b0, cyc, first);
        chk("post_rst_latency", first, 3);
        chk("post_rst_cycles", cyc, 13);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fb_scanout.md
FB_SCANOUT -- requirements
Module: fb_scanout

Interface
REQ-001 SHALL have parameter FRAME_WORDS, default 4800, the number of 16-bit words per frame (1..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 0, the first word address of the frame (BASE_ADDR+FRAME_WORDS <= 65536).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the pixel FIFO depth (power of two, >= 2).
REQ-004 clk  in  1  sole clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 enable  in  1  scanout run request.
REQ-007 mem_addr  out  16  word address to the memory.
REQ-008 mem_we  out  4  nibble write mask to the memory (0 = read).
REQ-009 mem_wdata  out  16  write data to the memory.
REQ-010 mem_rdata  in  16  read data, valid exactly 1 cycle after a read address is presented.
REQ-011 wr_valid / wr_ready  in / out  1 / 1  host write handshake.
REQ-012 wr_addr / wr_data / wr_mask  in  16 / 16 / 4  host write address, data and nibble mask.
REQ-013 px_valid / px_ready  out / in  1 / 1  pixel stream handshake.
REQ-014 px_data  out  16  pixel word.
REQ-015 px_sof  out  1  high with the word read from BASE_ADDR (first word of a frame).

Function
REQ-016 SHALL implement states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-017 On RUN->IDLE SHALL flush the FIFO, discard any in-flight read, and reset the read pointer to BASE_ADDR.
REQ-018 Credits = FIFO occupancy + in-flight reads (0 or 1); a read SHALL be issued only in RUN with credits < FIFO_DEPTH.
REQ-019 Per-cycle arbitration: issue the host write when wr_valid=1 and (state=IDLE or credits >= 2); otherwise issue a read if allowed; otherwise idle.
REQ-020 wr_ready SHALL be combinationally high exactly in cycles where the write is issued; the transfer occurs on wr_valid&wr_ready.
REQ-021 Issued write: mem_addr=wr_addr, mem_we=wr_mask, mem_wdata=wr_data in the same cycle; wr_mask=0 SHALL still be accepted (no-op).
REQ-022 Issued read: mem_addr=read pointer, mem_we=0; read pointer increments by 1 and wraps from BASE_ADDR+FRAME_WORDS-1 to BASE_ADDR.
REQ-023 Idle cycle: mem_we=0; mem_addr and mem_wdata are don't-care.
REQ-024 mem_rdata of a read issued in cycle N SHALL be written into the FIFO at the end of cycle N+1, tagged sof if its address was BASE_ADDR.
REQ-025 px_valid SHALL equal FIFO non-empty; px_data/px_sof SHALL present the FIFO head; pop on px_valid&px_ready.
REQ-026 Simultaneous FIFO push and pop SHALL both occur; occupancy unchanged.
REQ-027 Credit rule guarantees no FIFO overflow; a push into a full FIFO SHALL NOT occur.
REQ-028 px_data/px_sof SHALL remain stable while px_valid=1 and px_ready=0.
REQ-029 Minimum latency: enable rising at edge E -> first read at cycle E+1 -> px_valid=1 at cycle E+3.
REQ-030 With px_ready held high and no writes, sustained throughput SHALL be one word per cycle.

Reset
REQ-031 During and after rst: state=IDLE, read pointer=BASE_ADDR, FIFO empty, no in-flight read.
REQ-032 Reset values: px_valid=0, px_sof=0, mem_we=0, wr_ready=0 while wr_valid=0, px_data=0, mem_addr=0.
REQ-033 Reset asserted mid-frame SHALL take effect immediately (asynchronous); the first frame after release restarts at BASE_ADDR with px_sof.

Verification
REQ-034 Memory model preloaded word[i]=i, FRAME_WORDS=8, enable=1, px_ready=1 -> px_data 0,1..7,0,1... with px_sof high on each 0; first px_valid 3 cycles after enable.
REQ-035 px_ready=0 for 20 cycles in RUN -> FIFO fills to FIFO_DEPTH; then no further reads (mem_we=0, pointer frozen); px_data stable; no word lost or duplicated after release.
REQ-036 enable=0, wr_valid=1 with wr_addr=3, wr_data=16'hABCD, wr_mask=4'hF -> wr_ready=1 same cycle, mem_we=4'hF; after enable=1 the fourth scanned word is 16'hABCD.
REQ-037 RUN with FIFO full, wr_valid held high with 3 writes -> one write per cycle while credits >= 2; pixel order unaffected.
REQ-038 Deassert enable mid-frame at word 5, reassert 2 cycles later -> px_valid drops next cycle; the stream restarts at word 0 with px_sof=1.
REQ-039 Assert rst mid-frame with px_valid=1 -> px_valid=0, mem_we=0 immediately; the frame after release starts at word 0.
